// File: rtl/b2xx_reset_pkg.sv
// Shared definitions for the B2xx reset sequencer: state encoding, loss counter width
// and the counter-width helper used to size the sequencing counters.
package b2xx_reset_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLDOFF   = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  localparam int LOSS_CNT_W = 8;

  // Counters run 0..n-1, so $clog2(n) bits suffice; keep at least one bit for n=1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/b2xx_reset_seq_synchronizer.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/b2xx_reset_seq.sv
// Ordered reset release: debounce clock lock, hold off, then drop resets one by one,
// restarting on lock loss or software request and counting lock losses.
module b2xx_reset_seq
  import b2xx_reset_pkg::*;
#(
  parameter int NUM_RST  = 3,
  parameter int HOLDOFF  = 65535,
  parameter int STAGGER  = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  soft_rst,
  output logic [NUM_RST-1:0]    rst_out,
  output logic                  clocks_ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]            state
);

  localparam int DEB_W  = cnt_width(DEBOUNCE);
  localparam int HOLD_W = cnt_width(HOLDOFF);
  localparam int STAG_W = cnt_width(STAGGER);
  localparam int IDX_W  = cnt_width(NUM_RST);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_RST - 1);

  logic locked_s;

  synchronizer #(.STAGES(2)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  seq_state_e             state_q, state_d;
  logic [DEB_W-1:0]       deb_q, deb_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [STAG_W-1:0]      stag_q, stag_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_RST-1:0]     rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_LOCK;
      deb_q   <= '0;
      hold_q  <= '0;
      stag_q  <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;

    if (state_q == ST_WAIT_LOCK) begin
      if (!locked_s || soft_rst) begin
        deb_d = '0;
      end else if (deb_q == DEB_LAST) begin
        state_d = ST_HOLDOFF;
        deb_d   = '0;
        hold_d  = '0;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end else if (!locked_s || soft_rst) begin
      // Lock loss wins over a coincident soft reset so the event is counted once.
      state_d = ST_WAIT_LOCK;
      deb_d   = '0;
      hold_d  = '0;
      stag_d  = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      if (!locked_s && (loss_q != '1)) begin
        loss_d = loss_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_HOLDOFF: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            stag_d  = '0;
            idx_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (stag_q == STAG_LAST) begin
            stag_d = '0;
            rst_d  = rst_q & ~(NUM_RST'(1) << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            stag_d = stag_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rst_out       = rst_q;
  assign clocks_ready  = ready_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule
